// File: rtl/debug_display_if.sv
// Debug-word bus between the processor core and the display selector.
// The master drives the debug words and the raw controls; the slave returns the display word and page.
interface debug_display_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] wb_data;
  logic        next_btn;
  logic        freeze_sw;
  logic [31:0] display;
  logic [1:0]  page;

  modport master (
    output pc, instr, alu_result, wb_data, next_btn, freeze_sw,
    input  display, page
  );

  modport slave (
    input  pc, instr, alu_result, wb_data, next_btn, freeze_sw,
    output display, page
  );
endinterface

// File: rtl/debug_display_select.sv
// Selects one of four debug words for the hex/LED display.
// The word is picked by a debounced page button and can be held by a freeze switch.
module debug_display_select #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  debug_display_if.slave  dbg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1_q, btn_s_q;
  logic          frz_s1_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    page_q, page_d;
  logic [31:0]   display_q, display_d;
  logic          frozen_d;
  logic          press;
  logic [23:0]   sel;

  // display_q[31] is the second synchronizer flop for freeze_sw, so frozen
  // and the displayed status bit can never disagree.
  assign frozen_d = frz_s1_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press    = 1'b0;
    if (btn_s_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = btn_s_q;
        press    = btn_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A press accepted on the same edge freeze asserts is dropped, not queued.
  assign page_d = (press && !frozen_d) ? page_q + 2'd1 : page_q;

  always_comb begin
    sel = '0;
    case (page_d)
      2'd0: sel = dbg.pc[23:0];
      2'd1: sel = dbg.instr[23:0];
      2'd2: sel = dbg.alu_result[23:0];
      2'd3: sel = dbg.wb_data[23:0];
      default: sel = '0;
    endcase
  end

  always_comb begin
    if (frozen_d)
      display_d = {1'b1, display_q[30:0]};
    else
      display_d = {1'b0, 3'b000, 4'b0001 << page_d, sel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q  <= 1'b0;
      btn_s_q   <= 1'b0;
      frz_s1_q  <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      page_q    <= 2'd0;
      display_q <= '0;
    end else begin
      btn_s1_q  <= dbg.next_btn;
      btn_s_q   <= btn_s1_q;
      frz_s1_q  <= dbg.freeze_sw;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      page_q    <= page_d;
      display_q <= display_d;
    end
  end

  assign dbg.display = display_q;
  assign dbg.page    = page_q;
endmodule
